// File: rtl/c_byte_fifo.sv
// Byte FIFO between rcu_inner and the core: first-word fall-through, seals on
// the terminator byte and flags completion once the core has popped it.
module c_byte_fifo #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [7:0]  TERM_BYTE = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   rd_term,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   sealed,
    output logic                   done,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_OPEN   = 2'd0,
        S_SEALED = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    // Entry layout: {term_tag, byte}
    logic [8:0]      mem_q [DEPTH];

    logic            empty_w;
    logic            full_w;
    logic            sealed_w;
    logic            rd_ok;
    logic            wr_ok;
    logic            wr_is_term;
    logic            mem_we;
    logic [8:0]      head;

    always_comb begin
        empty_w    = (count_q == '0);
        full_w     = (count_q == CW'(DEPTH));
        sealed_w   = (state_q != S_OPEN);
        rd_ok      = rd_en & ~empty_w;
        wr_ok      = wr_en & ~sealed_w & (~full_w | rd_ok);
        wr_is_term = (wr_data == TERM_BYTE);
        mem_we     = wr_ok & ~clear;
        head       = mem_q[rd_ptr_q];
    end

    // Next-state: pointers, occupancy, sticky flags and the seal/done FSM
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (clear) begin
            state_d  = S_OPEN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end

            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            // Writes after sealing are expected (rcu_inner repeats FF) and are not overflows
            if (wr_en & ~sealed_w & full_w & ~rd_ok) begin
                ovf_d = 1'b1;
            end
            if (rd_en & empty_w) begin
                unf_d = 1'b1;
            end

            case (state_q)
                S_OPEN: begin
                    if (wr_ok && wr_is_term) begin
                        state_d = S_SEALED;
                    end
                end
                S_SEALED: begin
                    if (rd_ok && head[8]) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_OPEN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_OPEN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage has no reset; the occupancy count masks stale entries
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {wr_is_term, wr_data};
        end
    end

    always_comb begin
        rd_data   = empty_w ? 8'h00 : head[7:0];
        rd_term   = empty_w ? 1'b0 : head[8];
        empty     = empty_w;
        full      = full_w;
        count     = count_q;
        sealed    = sealed_w;
        done      = (state_q == S_DONE);
        overflow  = ovf_q;
        underflow = unf_q;
    end

endmodule

// File: tb/tb_c_byte_fifo.sv
// Directed, table-driven bench for c_byte_fifo with hand-computed expectations.
module tb_c_byte_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_term;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       sealed;
    logic       done;
    logic       overflow;
    logic       underflow;

    int n_cmp = 0;
    int n_fail = 0;

    c_byte_fifo #(.DEPTH(8), .TERM_BYTE(8'hFF)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_term(rd_term), .empty(empty), .full(full),
        .count(count), .sealed(sealed), .done(done),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic [3:0] cnt;
        logic [7:0] rdd;
        logic       rterm;
        logic       seal;
        logic       dn;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic we, input logic [7:0] wd, input logic re,
                       input int cnt, input logic [7:0] rdd, input logic rterm,
                       input logic seal, input logic dn, input logic ovf, input logic unf);
        vec_t v;
        v.clr = clr; v.we = we; v.wd = wd; v.re = re;
        v.cnt = 4'(cnt); v.rdd = rdd; v.rterm = rterm;
        v.seal = seal; v.dn = dn; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_state(input int idx, input vec_t v);
        cmp("count",     idx, 32'(count),     32'(v.cnt));
        cmp("rd_data",   idx, 32'(rd_data),   32'(v.rdd));
        cmp("rd_term",   idx, 32'(rd_term),   32'(v.rterm));
        cmp("empty",     idx, 32'(empty),     32'(v.cnt == 4'd0));
        cmp("full",      idx, 32'(full),      32'(v.cnt == 4'd8));
        cmp("sealed",    idx, 32'(sealed),    32'(v.seal));
        cmp("done",      idx, 32'(done),      32'(v.dn));
        cmp("overflow",  idx, 32'(overflow),  32'(v.ovf));
        cmp("underflow", idx, 32'(underflow), 32'(v.unf));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle.clr = 0; idle.we = 0; idle.wd = 0; idle.re = 0; idle.cnt = 0; idle.rdd = 0;
        idle.rterm = 0; idle.seal = 0; idle.dn = 0; idle.ovf = 0; idle.unf = 0;

        // Ordering
        add(0, 1, 8'h33, 0, 1, 8'h33, 0, 0, 0, 0, 0);
        add(0, 1, 8'h21, 0, 2, 8'h33, 0, 0, 0, 0, 0);
        add(0, 1, 8'h12, 0, 3, 8'h33, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 2, 8'h21, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 8'h12, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        // Fill, overflow, drain
        for (int i = 1; i <= 8; i++) add(0, 1, 8'(i), 0, i, 8'h01, 0, 0, 0, 0, 0);
        add(0, 1, 8'h09, 0, 8, 8'h01, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, 8'h00, 1, 8 - k, (k < 8) ? 8'(k + 1) : 8'h00, 0, 0, 0, 1, 0);
        // Clear beats a simultaneous write and read
        add(1, 1, 8'hAA, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        // Simultaneous write+read while full
        for (int i = 0; i < 8; i++) add(0, 1, 8'(8'h41 + i), 0, i + 1, 8'h41, 0, 0, 0, 0, 0);
        add(0, 1, 8'h49, 1, 8, 8'h42, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, 8'h00, 1, 8 - k, (k < 8) ? 8'(8'h42 + k) : 8'h00, 0, 0, 0, 0, 0);
        // 3*DEPTH bytes streamed through, pointers wrap
        add(0, 1, 8'h80, 0, 1, 8'h80, 0, 0, 0, 0, 0);
        for (int i = 1; i < 24; i++) add(0, 1, 8'(8'h80 + i), 1, 1, 8'(8'h80 + i), 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0);
        // Terminator
        add(0, 1, 8'h34, 0, 1, 8'h34, 0, 0, 0, 0, 0);
        add(0, 1, 8'hFF, 0, 2, 8'h34, 0, 1, 0, 0, 0);
        add(0, 1, 8'h12, 0, 2, 8'h34, 0, 1, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 8'hFF, 1, 1, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 0);
        add(0, 1, 8'h77, 0, 0, 8'h00, 0, 1, 1, 0, 0);
        add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        // Underflow with simultaneous write when empty
        add(0, 1, 8'h55, 1, 1, 8'h55, 0, 0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 1, 8'h55, 0, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 1);
        // Clear while sealed with five entries
        for (int i = 1; i <= 4; i++) add(0, 1, 8'(i), 0, i, 8'h01, 0, 0, 0, 0, 1);
        add(0, 1, 8'hFF, 0, 5, 8'h01, 0, 1, 0, 0, 1);
        add(1, 1, 8'h66, 0, 0, 8'h00, 0, 0, 0, 0, 0);

        // Reset held with a write strobe present
        rst = 1'b1; clear = 1'b0; wr_en = 1'b1; wr_data = 8'h11; rd_en = 1'b0;
        tick();
        tick();
        check_state(-1, idle);
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        tick();
        check_state(-2, idle);

        foreach (vecs[i]) begin
            clear = vecs[i].clr; wr_en = vecs[i].we; wr_data = vecs[i].wd; rd_en = vecs[i].re;
            tick();
            check_state(i, vecs[i]);
        end

        // Asynchronous reset between edges
        clear = 1'b0; rd_en = 1'b0; wr_en = 1'b1; wr_data = 8'hC3;
        tick();
        wr_data = 8'hC4;
        tick();
        wr_en = 1'b0;
        cmp("pre_rst_count", -3, 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        cmp("async_empty", -3, 32'(empty), 32'd1);
        cmp("async_count", -3, 32'(count), 32'd0);
        cmp("async_rd_data", -3, 32'(rd_data), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check_state(-4, idle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
